// File: rtl/q_cycle_sequencer_pkg.sv
// q_cycle_sequencer_pkg: phase codes, sequencer states, defaults.
// Config macro Q_SEQ_INTERRUPT_EN (interrupt entry) is consumed by the top.
package q_cycle_sequencer_pkg;

  localparam int          DEF_PC_WIDTH   = 13;
  localparam logic [12:0] DEF_INT_VECTOR = 13'h004;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_t;

  typedef enum logic [2:0] {
    S_FILL,
    S_RUN,
    S_FLUSH_BR,
    S_FLUSH_SK,
    S_SLEEP,
    S_INT1,
    S_INT2
  } seq_state_t;

endpackage

// File: rtl/q_cycle_sequencer_if.sv
// q_cycle_sequencer_if: decoder outcomes in, cycle strobes out.
// master = sequencer, slave = core datapath side.
interface q_cycle_sequencer_if #(
  parameter int PC_WIDTH = 13
);
  logic                branch_taken;
  logic                skip_taken;
  logic                sleep_req;
  logic                int_pending;
  logic                wake;
  logic [1:0]          q_phase;
  logic                exec_valid;
  logic                incr_pc_en;
  logic                instr_rd_en;
  logic                instr_flush;
  logic                in_sleep;
  logic                stack_push;
  logic                gie_clr;
  logic                pc_vector_load;
  logic [PC_WIDTH-1:0] vector_addr;

  modport master (
    input  branch_taken, skip_taken, sleep_req,
    input  int_pending, wake,
    output q_phase, exec_valid, incr_pc_en,
    output instr_rd_en, instr_flush, in_sleep,
    output stack_push, gie_clr, pc_vector_load,
    output vector_addr
  );

  modport slave (
    output branch_taken, skip_taken, sleep_req,
    output int_pending, wake,
    input  q_phase, exec_valid, incr_pc_en,
    input  instr_rd_en, instr_flush, in_sleep,
    input  stack_push, gie_clr, pc_vector_load,
    input  vector_addr
  );
endinterface

// File: rtl/q_cycle_sequencer_phase_counter.sv
// q_phase_counter: free-running Q1..Q4 counter.
// hold parks the counter (used while the core sleeps at Q1).
module q_phase_counter
  import q_cycle_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [1:0] q_phase,
  output logic       q4_tick
);

  logic [1:0] r_q;

  // advance one phase per clock unless held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= Q1;
    end else if (!hold) begin
      r_q <= r_q + 2'd1;
    end
  end

  assign q_phase = r_q;
  assign q4_tick = (r_q == Q4);

endmodule

// File: rtl/q_cycle_sequencer.sv
// q_cycle_sequencer: Q1..Q4 instruction-cycle timing and strobes.
// Config macro Q_SEQ_INTERRUPT_EN enables the two-cycle interrupt entry.
module q_cycle_sequencer
  import q_cycle_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH   = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] INT_VECTOR = PC_WIDTH'(DEF_INT_VECTOR)
) (
  input  logic                 clk,
  input  logic                 rst,
  q_cycle_sequencer_if.master  bus
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic [1:0] w_q;
  logic       w_q4;
  logic       w_q1;
  logic       w_hold;
  logic       w_live;
  logic       w_exec;
  logic       w_incr;
  logic       w_rd;
  logic       w_flush;
  logic       w_sleep;
  logic       w_push;
  logic       w_gie;
  logic       w_vload;
  logic       w_int;

  assign w_hold = (r_state == S_SLEEP);
  assign w_q1   = (w_q == Q1);
  assign w_live = ~rst;

`ifdef Q_SEQ_INTERRUPT_EN
  assign w_int = bus.int_pending;
`else
  logic w_unused_int;
  assign w_unused_int = bus.int_pending;
  assign w_int        = 1'b0;
`endif

  q_phase_counter u_phase (
    .clk     (clk),
    .rst     (rst),
    .hold    (w_hold),
    .q_phase (w_q),
    .q4_tick (w_q4)
  );

  // one state per instruction cycle, updated at the Q4->Q1 edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and per-phase strobes
  always_comb begin
    w_state_nxt = r_state;
    w_exec      = 1'b0;
    w_incr      = 1'b0;
    w_rd        = 1'b0;
    w_flush     = 1'b0;
    w_sleep     = 1'b0;
    w_push      = 1'b0;
    w_gie       = 1'b0;
    w_vload     = 1'b0;
    unique case (r_state)
      S_FILL: begin
        w_rd = w_q4;
        if (w_q4) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_exec  = 1'b1;
        w_incr  = w_q1;
        w_rd    = w_q4;
        w_flush = w_q4 &
          (bus.branch_taken | bus.skip_taken);
        if (w_q4) begin
          if (bus.branch_taken)
            w_state_nxt = S_FLUSH_BR;
          else if (bus.skip_taken)
            w_state_nxt = S_FLUSH_SK;
          else if (bus.sleep_req)
            w_state_nxt = S_SLEEP;
          else if (w_int)
            w_state_nxt = S_INT1;
          else
            w_state_nxt = S_RUN;
        end
      end
      S_FLUSH_BR: begin
        w_rd = w_q4;
        if (w_q4) w_state_nxt = S_RUN;
      end
      S_FLUSH_SK: begin
        w_incr = w_q1;
        w_rd   = w_q4;
        if (w_q4) w_state_nxt = S_RUN;
      end
      S_SLEEP: begin
        w_sleep = 1'b1;
        if (bus.wake) w_state_nxt = S_RUN;
      end
`ifdef Q_SEQ_INTERRUPT_EN
      S_INT1: begin
        w_push  = w_q4;
        w_gie   = w_q4;
        w_flush = w_q4;
        w_rd    = w_q4;
        if (w_q4) w_state_nxt = S_INT2;
      end
      S_INT2: begin
        w_vload = w_q1;
        w_rd    = w_q4;
        if (w_q4) w_state_nxt = S_RUN;
      end
`else
      S_INT1, S_INT2: begin
        w_state_nxt = S_FILL;
      end
`endif
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  assign bus.q_phase        = w_live ? w_q : Q1;
  assign bus.exec_valid     = w_live & w_exec;
  assign bus.incr_pc_en     = w_live & w_incr;
  assign bus.instr_rd_en    = w_live & w_rd;
  assign bus.instr_flush    = w_live & w_flush;
  assign bus.in_sleep       = w_live & w_sleep;
  assign bus.stack_push     = w_live & w_push;
  assign bus.gie_clr        = w_live & w_gie;
  assign bus.pc_vector_load = w_live & w_vload;
  assign bus.vector_addr    = INT_VECTOR;

endmodule

// File: tb/tb_q_cycle_sequencer.sv
// tb_q_cycle_sequencer: directed + random instruction-cycle checks.
// Define Q_SEQ_INTERRUPT_EN for both bench and RTL to test interrupt entry.
module tb_q_cycle_sequencer;
  import q_cycle_sequencer_pkg::*;

  localparam int PW = 13;
`ifdef Q_SEQ_INTERRUPT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif

  typedef enum {K_FILL, K_RUN, K_FBR, K_FSK,
                K_SLEEP, K_INT1, K_INT2} kind_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  q_cycle_sequencer_if #(.PC_WIDTH(PW)) bus ();

  q_cycle_sequencer #(
    .PC_WIDTH   (PW),
    .INT_VECTOR (13'h004)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected strobes for one clock of an instruction cycle of kind k.
  // Order: q,exec,incr,rd,flush,sleep,push,gie,vload
  function automatic logic [9:0] expv(kind_t k, int p, bit brsk);
    logic [1:0] q;
    bit ex, inc, rd, fl, sl, pu, gi, vl, f, l;
    q  = 2'(p);
    f  = (p == 0);
    l  = (p == 3);
    ex = 0; inc = 0; rd = 0; fl = 0;
    sl = 0; pu = 0; gi = 0; vl = 0;
    case (k)
      K_FILL:  rd = l;
      K_RUN:   begin ex = 1; inc = f; rd = l; fl = l && brsk; end
      K_FBR:   rd = l;
      K_FSK:   begin inc = f; rd = l; end
      K_SLEEP: begin q = 2'd0; sl = 1; end
      K_INT1:  begin rd = l; fl = l; pu = l; gi = l; end
      K_INT2:  begin vl = f; rd = l; end
      default: ;
    endcase
    return {q, ex, inc, rd, fl, sl, pu, gi, vl};
  endfunction

  // Which instruction cycle follows, from the decoder outcome at Q4.
  function automatic kind_t model_next(kind_t k, bit br, bit sk,
                                       bit sl, bit ip);
    case (k)
      K_RUN: begin
        if (br)                return K_FBR;
        else if (sk)           return K_FSK;
        else if (sl)           return K_SLEEP;
        else if (ip && INT_ON) return K_INT1;
        else                   return K_RUN;
      end
      K_INT1:  return K_INT2;
      default: return K_RUN;
    endcase
  endfunction

  function automatic logic [9:0] obs();
    return {bus.q_phase, bus.exec_valid, bus.incr_pc_en,
            bus.instr_rd_en, bus.instr_flush, bus.in_sleep,
            bus.stack_push, bus.gie_clr, bus.pc_vector_load};
  endfunction

  task automatic chk(input string tag, input logic [9:0] e);
    logic [9:0] o;
    @(negedge clk);
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, o, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag);
    checks++;
    assert (bus.vector_addr === 13'h004) else begin
      errors++;
      $error("FAIL %s obs=%h exp=004", tag, bus.vector_addr);
    end
  endtask

  task automatic noise();
    bus.branch_taken = 1'($urandom_range(0, 1));
    bus.skip_taken   = 1'($urandom_range(0, 1));
    bus.sleep_req    = 1'($urandom_range(0, 1));
    bus.int_pending  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_cycle(input kind_t k, input bit br, input bit sk,
                          input bit sl, input bit ip,
                          output kind_t nk);
    for (int p = 0; p < 4; p++) begin
      if (p == 3) begin
        bus.branch_taken = br;
        bus.skip_taken   = sk;
        bus.sleep_req    = sl;
        bus.int_pending  = ip;
      end else begin
        noise();
      end
      bus.wake = 1'($urandom_range(0, 1));
      if (k == K_INT2 && p == 0) chk_vec("vector_addr");
      chk($sformatf("%s_q%0d", k.name(), p + 1),
          expv(k, p, br | sk));
    end
    nk = model_next(k, br, sk, sl, ip);
  endtask

  task automatic do_sleep(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      bus.wake = 1'b0;
      chk("sleep_hold", expv(K_SLEEP, 0, 0));
    end
    noise();
    bus.wake = 1'b1;
    chk("sleep_wake", expv(K_SLEEP, 0, 0));
    bus.wake = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kind_t k;
    bit br, sk, sl, ip;
    rst              = 1'b1;
    bus.branch_taken = 1'b0;
    bus.skip_taken   = 1'b0;
    bus.sleep_req    = 1'b0;
    bus.int_pending  = 1'b0;
    bus.wake         = 1'b0;
    @(posedge clk);
    #1;
    // reset held two clocks, everything quiet
    chk("rst_1", 10'd0);
    chk("rst_2", 10'd0);
    chk_vec("vector_addr_rst");
    rst = 1'b0;

    // fill then first real instruction
    do_cycle(K_FILL, 0, 0, 0, 0, k);
    do_cycle(k, 0, 0, 0, 0, k);

    // branch, then skip
    do_cycle(k, 1, 0, 0, 0, k);
    do_cycle(k, 0, 0, 0, 0, k);
    do_cycle(k, 0, 1, 0, 0, k);
    do_cycle(k, 0, 0, 0, 0, k);

    // priority: branch over skip, skip over sleep
    do_cycle(k, 1, 1, 1, 1, k);
    do_cycle(k, 0, 0, 0, 0, k);
    do_cycle(k, 0, 1, 1, 1, k);
    do_cycle(k, 0, 0, 0, 0, k);

    // sleep for 20 clocks then wake
    do_cycle(k, 0, 0, 1, 0, k);
    do_sleep(20);
    do_cycle(K_RUN, 0, 0, 0, 0, k);

    // interrupt entry (or ignored when disabled)
    do_cycle(k, 0, 0, 0, 1, k);
    do_cycle(k, 0, 0, 0, 0, k);
    do_cycle(k, 0, 0, 0, 0, k);
    do_cycle(k, 1, 0, 0, 1, k);
    do_cycle(k, 0, 0, 0, 1, k);
    do_cycle(k, 0, 0, 0, 0, k);
    do_cycle(k, 0, 0, 0, 0, k);
    while (k != K_RUN) do_cycle(k, 0, 0, 0, 0, k);

    // reset arriving at Q3 of a running cycle
    noise();
    chk("mid_q1", expv(K_RUN, 0, 0));
    noise();
    chk("mid_q2", expv(K_RUN, 1, 0));
    rst = 1'b1;
    noise();
    chk("mid_rst", 10'd0);
    rst = 1'b0;
    do_cycle(K_FILL, 1, 1, 1, 1, k);
    do_cycle(k, 0, 0, 0, 0, k);

    // random instruction stream
    for (int i = 0; i < 120; i++) begin
      if (k == K_SLEEP) begin
        do_sleep($urandom_range(0, 5));
        k = K_RUN;
      end else begin
        br = ($urandom_range(0, 5) == 0);
        sk = ($urandom_range(0, 5) == 0);
        sl = ($urandom_range(0, 7) == 0);
        ip = ($urandom_range(0, 4) == 0);
        do_cycle(k, br, sk, sl, ip, k);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
